// File: rtl/meta_rr_arbiter.sv
// Round-robin arbiter sharing one meta valid/ready/data channel between N_SRC sources.
// It has an optional per-grant burst hold and a registered output stage that tags each beat with its source index.
module meta_rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_BITS = 32,
  parameter int MAX_BURST = 1,
  localparam int ID_BITS  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_SRC-1:0]           s_valid,
  output logic [N_SRC-1:0]           s_ready,
  input  logic [N_SRC*DATA_BITS-1:0] s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_BITS-1:0]       m_data,
  output logic [ID_BITS-1:0]         m_id
);

  localparam int CNT_BITS = $clog2(MAX_BURST + 1);

  logic [ID_BITS-1:0]  rr_ptr;
  logic [ID_BITS-1:0]  cur;
  logic [ID_BITS-1:0]  grant;
  logic [ID_BITS-1:0]  scan_base;
  logic [CNT_BITS-1:0] burst_cnt;
  logic [CNT_BITS-1:0] nxt_cnt;
  logic                hold;
  logic                en;
  logic                load_en;
  logic                granted;
  logic                xfer;
  logic                hold_keep;
  logic                hold_drop;
  logic                burst_done;

  function automatic logic [ID_BITS-1:0] wrap_inc(input logic [ID_BITS-1:0] v);
    if (int'(v) == N_SRC - 1) return '0;
    return v + 1'b1;
  endfunction

  // Handshake: a beat moves when valid and ready are both high at a clock edge; valid never
  // waits on ready, and a source holds valid/data stable until its beat moves.
  assign load_en   = !m_valid | m_ready;
  assign hold_keep = hold & s_valid[cur];
  assign hold_drop = hold & !s_valid[cur];
  // A holder that dropped out is skipped in the same cycle by scanning from the slot after it.
  assign scan_base = hold_drop ? wrap_inc(cur) : rr_ptr;

  always_comb begin
    int idx;
    granted = 1'b0;
    grant   = '0;
    idx     = 0;
    if (hold_keep) begin
      granted = 1'b1;
      grant   = cur;
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        idx = int'(scan_base) + k;
        if (idx >= N_SRC) idx = idx - N_SRC;
        if (!granted && s_valid[idx]) begin
          granted = 1'b1;
          grant   = ID_BITS'(idx);
        end
      end
    end
  end

  // en keeps every s_ready low until the first edge after reset release.
  assign xfer = en & load_en & granted;

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      s_ready[i] = xfer & (grant == ID_BITS'(i));
    end
  end

  assign nxt_cnt    = hold_keep ? burst_cnt + 1'b1 : CNT_BITS'(1);
  assign burst_done = int'(nxt_cnt) >= MAX_BURST;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      en        <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_id      <= '0;
      rr_ptr    <= '0;
      cur       <= '0;
      burst_cnt <= '0;
      hold      <= 1'b0;
    end else begin
      en <= 1'b1;
      if (load_en) m_valid <= xfer;
      if (xfer) begin
        m_data <= s_data[int'(grant)*DATA_BITS +: DATA_BITS];
        m_id   <= grant;
        cur    <= grant;
        if (burst_done) begin
          hold      <= 1'b0;
          burst_cnt <= '0;
          rr_ptr    <= wrap_inc(grant);
        end else begin
          hold      <= 1'b1;
          burst_cnt <= nxt_cnt;
          if (hold_drop) rr_ptr <= wrap_inc(cur);
        end
      end else if (hold_drop) begin
        hold      <= 1'b0;
        burst_cnt <= '0;
        rr_ptr    <= wrap_inc(cur);
      end
    end
  end

endmodule

// File: tb/tb_meta_rr_arbiter.sv
// Directed bench for meta_rr_arbiter: three instances (MAX_BURST 1, 4, 2) share stimulus,
// each scenario task checks the instance it targets.
module tb_meta_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     s_valid;
  logic [N*W-1:0]   s_data;
  logic             m_ready;

  logic [N-1:0]     s_ready_a, s_ready_b, s_ready_c;
  logic             m_valid_a, m_valid_b, m_valid_c;
  logic [W-1:0]     m_data_a, m_data_b, m_data_c;
  logic [1:0]       m_id_a, m_id_b, m_id_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q [N][$];

  meta_rr_arbiter #(.N_SRC(N), .DATA_BITS(W), .MAX_BURST(1)) dut_a (
    .aclk(clk), .areset(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_id(m_id_a));

  meta_rr_arbiter #(.N_SRC(N), .DATA_BITS(W), .MAX_BURST(4)) dut_b (
    .aclk(clk), .areset(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_id(m_id_b));

  meta_rr_arbiter #(.N_SRC(N), .DATA_BITS(W), .MAX_BURST(2)) dut_c (
    .aclk(clk), .areset(rst), .s_valid(s_valid), .s_ready(s_ready_c), .s_data(s_data),
    .m_valid(m_valid_c), .m_ready(m_ready), .m_data(m_data_c), .m_id(m_id_c));

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base_data();
    for (int i = 0; i < N; i++) s_data[i*W +: W] = W'(32'h100 + i);
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    rst     = 1'b1;
    s_valid = v;
    m_ready = 1'b1;
    set_base_data();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 4'hF;
    m_ready = 1'b1;
    set_base_data();
    #1 rst = 1'b1;
    #2;
    n_checks++; if (m_valid_a !== 1'b0) $display("FAIL rst_m_valid_a: got %0b want 0", m_valid_a); else n_pass++;
    n_checks++; if (m_data_a !== '0) $display("FAIL rst_m_data_a: got %0h want 0", m_data_a); else n_pass++;
    n_checks++; if (m_id_a !== 2'd0) $display("FAIL rst_m_id_a: got %0d want 0", m_id_a); else n_pass++;
    n_checks++; if (s_ready_a !== 4'h0) $display("FAIL rst_s_ready_a: got %0b want 0000", s_ready_a); else n_pass++;
    n_checks++; if (m_valid_b !== 1'b0) $display("FAIL rst_m_valid_b: got %0b want 0", m_valid_b); else n_pass++;
    n_checks++; if (s_ready_b !== 4'h0) $display("FAIL rst_s_ready_b: got %0b want 0000", s_ready_b); else n_pass++;
    step();
    n_checks++; if (m_valid_a !== 1'b0) $display("FAIL rst_edge_m_valid: got %0b want 0", m_valid_a); else n_pass++;
    n_checks++; if (s_ready_c !== 4'h0) $display("FAIL rst_edge_s_ready_c: got %0b want 0000", s_ready_c); else n_pass++;
  endtask

  task automatic test_round_robin();
    int id;
    do_reset(4'hF);
    step();
    n_checks++; if (m_valid_a !== 1'b0) $display("FAIL rr_first_edge_idle: got %0b want 0", m_valid_a); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      step();
      id = k % N;
      n_checks++; if (m_valid_a !== 1'b1) $display("FAIL rr_valid[%0d]: got %0b want 1", k, m_valid_a); else n_pass++;
      n_checks++; if (m_id_a !== 2'(id)) $display("FAIL rr_id[%0d]: got %0d want %0d", k, m_id_a, id); else n_pass++;
      n_checks++; if (m_data_a !== W'(32'h100 + id)) $display("FAIL rr_data[%0d]: got %0h want %0h", k, m_data_a, 32'h100 + id); else n_pass++;
      n_checks++; if (s_ready_a !== 4'(1 << ((id + 1) % N))) $display("FAIL rr_s_ready[%0d]: got %0b want %0b", k, s_ready_a, 4'(1 << ((id + 1) % N))); else n_pass++;
    end
  endtask

  task automatic test_burst();
    int id;
    do_reset(4'hF);
    for (int t = 0; t < 4 && !m_valid_b; t++) step();
    n_checks++; if (m_valid_b !== 1'b1) $display("FAIL burst_start: got %0b want 1", m_valid_b); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      id = (k / 4) % N;
      n_checks++; if (m_id_b !== 2'(id)) $display("FAIL burst_id[%0d]: got %0d want %0d", k, m_id_b, id); else n_pass++;
      n_checks++; if (m_data_b !== W'(32'h100 + id)) $display("FAIL burst_data[%0d]: got %0h want %0h", k, m_data_b, 32'h100 + id); else n_pass++;
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]   held_id;
    logic [W-1:0] held_data;
    int           nxt;
    do_reset(4'hF);
    for (int t = 0; t < 4 && !m_valid_a; t++) step();
    step();
    held_id   = m_id_a;
    held_data = m_data_a;
    m_ready   = 1'b0;
    #1;
    n_checks++; if (s_ready_a !== 4'h0) $display("FAIL bp_s_ready_now: got %0b want 0000", s_ready_a); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (m_valid_a !== 1'b1) $display("FAIL bp_valid[%0d]: got %0b want 1", k, m_valid_a); else n_pass++;
      n_checks++; if (m_id_a !== held_id) $display("FAIL bp_id[%0d]: got %0d want %0d", k, m_id_a, held_id); else n_pass++;
      n_checks++; if (m_data_a !== held_data) $display("FAIL bp_data[%0d]: got %0h want %0h", k, m_data_a, held_data); else n_pass++;
      n_checks++; if (s_ready_a !== 4'h0) $display("FAIL bp_s_ready[%0d]: got %0b want 0000", k, s_ready_a); else n_pass++;
    end
    m_ready = 1'b1;
    step();
    nxt = (int'(held_id) + 1) % N;
    n_checks++; if (m_id_a !== 2'(nxt)) $display("FAIL bp_release_id: got %0d want %0d", m_id_a, nxt); else n_pass++;
    n_checks++; if (m_data_a !== W'(32'h100 + nxt)) $display("FAIL bp_release_data: got %0h want %0h", m_data_a, 32'h100 + nxt); else n_pass++;
  endtask

  task automatic test_random_traffic();
    logic [N-1:0] sent;
    int           seq [N];
    int           beats_in;
    int           left;
    logic [W-1:0] exp;
    do_reset(4'h0);
    sent     = '0;
    beats_in = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int cyc = 0; cyc < 20000 && beats_in < 1000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (sent[i] || !s_valid[i]) begin
          s_valid[i] = ($urandom_range(0, 3) != 0);
          if (s_valid[i]) begin
            s_data[i*W +: W] = {8'(i), 24'(seq[i])};
            seq[i]++;
          end
        end
      end
      sent    = '0;
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (m_valid_a && m_ready) begin
        n_checks++;
        if (exp_q[int'(m_id_a)].size() == 0) begin
          $display("FAIL sb_unexpected: got id %0d data %0h want no beat", m_id_a, m_data_a);
        end else begin
          exp = exp_q[int'(m_id_a)].pop_front();
          if (m_data_a !== exp) $display("FAIL sb_data: got %0h want %0h (id %0d)", m_data_a, exp, m_id_a);
          else n_pass++;
        end
      end
      if (m_valid_a && !m_ready) begin
        n_checks++; if (s_ready_a !== 4'h0) $display("FAIL sb_stall_ready: got %0b want 0000", s_ready_a); else n_pass++;
      end
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && s_ready_a[i]) begin
          exp_q[i].push_back(s_data[i*W +: W]);
          sent[i] = 1'b1;
          beats_in++;
        end
      end
      step();
    end
    s_valid = '0;
    m_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      if (m_valid_a) begin
        n_checks++;
        if (exp_q[int'(m_id_a)].size() == 0) begin
          $display("FAIL sb_drain_unexpected: got id %0d data %0h want no beat", m_id_a, m_data_a);
        end else begin
          exp = exp_q[int'(m_id_a)].pop_front();
          if (m_data_a !== exp) $display("FAIL sb_drain_data: got %0h want %0h", m_data_a, exp);
          else n_pass++;
        end
      end
      step();
    end
    left = 0;
    for (int i = 0; i < N; i++) left += exp_q[i].size();
    n_checks++; if (beats_in !== 1000) $display("FAIL sb_beats_in: got %0d want 1000", beats_in); else n_pass++;
    n_checks++; if (left !== 0) $display("FAIL sb_lost_beats: got %0d want 0", left); else n_pass++;
  endtask

  task automatic test_sole_requester();
    logic seen0;
    do_reset(4'b0100);
    for (int t = 0; t < 4 && !m_valid_c; t++) step();
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (m_valid_c !== 1'b1) $display("FAIL sole_valid[%0d]: got %0b want 1", k, m_valid_c); else n_pass++;
      n_checks++; if (m_id_c !== 2'd2) $display("FAIL sole_id[%0d]: got %0d want 2", k, m_id_c); else n_pass++;
      step();
    end
    s_valid[0] = 1'b1;
    seen0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (m_valid_c !== 1'b1) $display("FAIL sole_join_valid[%0d]: got %0b want 1", k, m_valid_c); else n_pass++;
      if (m_id_c === 2'd0) seen0 = 1'b1;
    end
    n_checks++; if (seen0 !== 1'b1) $display("FAIL sole_join_grant: got %0b want 1 (src0 within 2 beats)", seen0); else n_pass++;
  endtask

  task automatic test_valid_drop();
    logic [1:0] exp_ids [7];
    exp_ids = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
    do_reset(4'b1010);
    for (int t = 0; t < 4 && !m_valid_b; t++) step();
    for (int k = 0; k < 7; k++) begin
      n_checks++; if (m_valid_b !== 1'b1) $display("FAIL drop_valid[%0d]: got %0b want 1", k, m_valid_b); else n_pass++;
      n_checks++; if (m_id_b !== exp_ids[k]) $display("FAIL drop_id[%0d]: got %0d want %0d", k, m_id_b, exp_ids[k]); else n_pass++;
      n_checks++; if (m_data_b !== W'(32'h100 + int'(exp_ids[k]))) $display("FAIL drop_data[%0d]: got %0h want %0h", k, m_data_b, 32'h100 + int'(exp_ids[k])); else n_pass++;
      if (k == 1) s_valid[1] = 1'b0;
      if (k == 2) s_valid[1] = 1'b1;
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset(4'hF);
    for (int t = 0; t < 4 && !m_valid_b; t++) step();
    for (int t = 0; t < 8 && m_id_b !== 2'd1; t++) step();
    n_checks++; if (m_id_b !== 2'd1) $display("FAIL mid_pre_id: got %0d want 1", m_id_b); else n_pass++;
    n_checks++; if (s_ready_b !== 4'b0010) $display("FAIL mid_pre_s_ready: got %0b want 0010", s_ready_b); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (m_valid_b !== 1'b0) $display("FAIL mid_async_valid: got %0b want 0", m_valid_b); else n_pass++;
    n_checks++; if (s_ready_b !== 4'h0) $display("FAIL mid_async_s_ready: got %0b want 0000", s_ready_b); else n_pass++;
    n_checks++; if (m_id_b !== 2'd0) $display("FAIL mid_async_id: got %0d want 0", m_id_b); else n_pass++;
    n_checks++; if (m_data_b !== '0) $display("FAIL mid_async_data: got %0h want 0", m_data_b); else n_pass++;
    step();
    step();
    rst = 1'b0;
    for (int t = 0; t < 4 && !m_valid_b; t++) step();
    n_checks++; if (m_valid_b !== 1'b1) $display("FAIL mid_restart_valid: got %0b want 1", m_valid_b); else n_pass++;
    n_checks++; if (m_id_b !== 2'd0) $display("FAIL mid_restart_id: got %0d want 0", m_id_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_random_traffic();
    test_sole_requester();
    test_valid_drop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
